// File: rtl/fft1024_twiddle_rom.sv
// Registered twiddle-factor ROM for a 1024-point radix-2 FFT.
// Returns W(n) = exp(-j*2*pi*n/1024) as packed Q1.15 {re, im}, one cycle after in_valid.
// Only a 257-entry quarter-wave cosine table is kept; the four quadrants are rebuilt
// from C[k] and C[256-k] with sign flips.
// Optional build macro: FFT_TWIDDLE_INVERSE_EN adds an 'inverse' input that conjugates
// the result (im negated) so the same ROM serves the IFFT.
module fft1024_twiddle_rom #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_W-1:0]     n,
`ifdef FFT_TWIDDLE_INVERSE_EN
    input  logic                  inverse,
`endif
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   twiddle
);

    localparam int unsigned MAG_W  = DATA_W - 1;
    localparam int unsigned K_W    = ADDR_W - 2;
    localparam int unsigned IDX_W  = K_W + 1;
    localparam int          QTR    = 1 << K_W;
    localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;
    localparam logic [2*DATA_W-1:0] TW_RESET = {1'b0, {(DATA_W-1){1'b1}}, {DATA_W{1'b0}}};

    // round(32768*cos(pi*k/512)), half away from zero, saturated to 32767.
    // Evaluated only at elaboration (integer Taylor series in Q60) to fill the constant ROM.
    function automatic logic [14:0] cos_q15(input int unsigned k);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] rnd;
        logic [14:0]  res;
        x    = (128'(PI_Q60) * 128'(k)) >> 9;
        x2   = (x * x) >> 60;
        term = 128'(1) << 60;
        sum  = term;
        for (int unsigned i = 1; i <= 12; i++) begin
            term = ((term * x2) >> 60) / 128'((2 * i - 1) * (2 * i));
            if (i[0]) sum = sum - term;
            else      sum = sum + term;
        end
        rnd = (sum + (128'(1) << 44)) >> 45;
        if (k >= 32'd256)              res = 15'd0;
        else if (rnd > 128'd32767)     res = 15'h7FFF;
        else                           res = rnd[14:0];
        return res;
    endfunction

    // Quarter-wave cosine magnitudes C[0..256], all constants.
    logic [MAG_W-1:0] cos_rom [0:QTR];

    for (genvar g = 0; g <= QTR; g++) begin : g_rom
        localparam logic [MAG_W-1:0] ENTRY = MAG_W'(cos_q15(g));
        assign cos_rom[g] = ENTRY;
    end

    logic [1:0]        q_c;
    logic [IDX_W-1:0]  k_c;
    logic [IDX_W-1:0]  kc_c;
    logic [MAG_W-1:0]  mag_a_c;
    logic [MAG_W-1:0]  mag_b_c;
    logic [DATA_W-1:0] pos_a_c;
    logic [DATA_W-1:0] neg_a_c;
    logic [DATA_W-1:0] pos_b_c;
    logic [DATA_W-1:0] neg_b_c;
    logic [DATA_W-1:0] re_c;
    logic [DATA_W-1:0] im_fwd_c;
    logic [DATA_W-1:0] im_c;

    // Split the index into quadrant and in-quadrant offset; fetch C[k] and C[256-k].
    always_comb begin
        q_c     = n[ADDR_W-1:ADDR_W-2];
        k_c     = {1'b0, n[K_W-1:0]};
        kc_c    = IDX_W'(QTR) - k_c;
        mag_a_c = cos_rom[k_c];
        mag_b_c = cos_rom[kc_c];
        pos_a_c = {1'b0, mag_a_c};
        pos_b_c = {1'b0, mag_b_c};
        neg_a_c = -{1'b0, mag_a_c};
        neg_b_c = -{1'b0, mag_b_c};
    end

    // Quadrant sign/swap mapping; magnitudes stop at 32767 so negation never overflows.
    always_comb begin
        re_c     = pos_a_c;
        im_fwd_c = neg_b_c;
        case (q_c)
            2'd0: begin re_c = pos_a_c; im_fwd_c = neg_b_c; end
            2'd1: begin re_c = neg_b_c; im_fwd_c = neg_a_c; end
            2'd2: begin re_c = neg_a_c; im_fwd_c = pos_b_c; end
            default: begin re_c = pos_b_c; im_fwd_c = pos_a_c; end
        endcase
`ifdef FFT_TWIDDLE_INVERSE_EN
        im_c = inverse ? -im_fwd_c : im_fwd_c;
`else
        im_c = im_fwd_c;
`endif
    end

    // Output register: reset wins, otherwise capture on in_valid and hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            twiddle   <= TW_RESET;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                twiddle <= {re_c, im_c};
            end
        end
    end

endmodule

// File: tb/tb_fft1024_twiddle_rom.sv
// Self-checking bench for fft1024_twiddle_rom: directed vector table, reset/hold
// sequences, and a full 0..1023 sweep against a floating-point reference.
// Build with FFT_TWIDDLE_INVERSE_EN defined to also exercise the conjugate path.
module tb_fft1024_twiddle_rom;

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic [9:0]  n;
        logic        inv;
        logic        exp_valid;
        logic [31:0] exp_tw;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [9:0]  n = 10'd0;
    logic        out_valid;
    logic [31:0] twiddle;
`ifdef FFT_TWIDDLE_INVERSE_EN
    logic        inverse = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fft1024_twiddle_rom dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .n         (n),
`ifdef FFT_TWIDDLE_INVERSE_EN
        .inverse   (inverse),
`endif
        .out_valid (out_valid),
        .twiddle   (twiddle)
    );

    function automatic vec_t mk(input logic r, input logic iv, input int unsigned idx,
                                input logic inv, input logic ev, input logic [31:0] et);
        vec_t v;
        v.rst       = r;
        v.in_valid  = iv;
        v.n         = 10'(idx);
        v.inv       = inv;
        v.exp_valid = ev;
        v.exp_tw    = et;
        return v;
    endfunction

    // Drive one cycle of inputs and advance to just after the sampling edge.
    task automatic drive(input logic r, input logic iv, input logic [9:0] idx, input logic inv);
        rst      = r;
        in_valid = iv;
        n        = idx;
`ifdef FFT_TWIDDLE_INVERSE_EN
        inverse  = inv;
`else
        if (inv) $display("note: inverse request ignored in forward-only build");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [31:0] et);
        n_tests++;
        if (out_valid !== ev || twiddle !== et) begin
            n_fail++;
            $display("FAIL %s: got out_valid=%0b twiddle=%08h, expected out_valid=%0b twiddle=%08h",
                     name, out_valid, twiddle, ev, et);
        end
    endtask

    function automatic int round_sat(input real x);
        real r;
        int  v;
        if (x >= 0.0) r = $floor(x + 0.5);
        else          r = -$floor(-x + 0.5);
        v = $rtoi(r);
        if (v > 32767)  v = 32767;
        if (v < -32767) v = -32767;
        return v;
    endfunction

    initial begin
        // Reset, quadrant/octant points, fine resolution, hold, reset priority.
        vecs.push_back(mk(1, 0,    0, 0, 0, 32'h7FFF0000));
        vecs.push_back(mk(1, 0,    0, 0, 0, 32'h7FFF0000));
        vecs.push_back(mk(0, 1,    0, 0, 1, 32'h7FFF0000));
        vecs.push_back(mk(0, 1,  128, 0, 1, 32'h5A82A57E));
        vecs.push_back(mk(0, 1,  256, 0, 1, 32'h00008001));
        vecs.push_back(mk(0, 1,  512, 0, 1, 32'h80010000));
        vecs.push_back(mk(0, 1,  768, 0, 1, 32'h00007FFF));
        vecs.push_back(mk(0, 1,    1, 0, 1, 32'h7FFFFF37));
        vecs.push_back(mk(0, 1, 1023, 0, 1, 32'h7FFF00C9));
        vecs.push_back(mk(0, 1,  384, 0, 1, 32'hA57EA57E));
        vecs.push_back(mk(0, 1,  640, 0, 1, 32'hA57E5A82));
        vecs.push_back(mk(0, 1,  896, 0, 1, 32'h5A825A82));
        vecs.push_back(mk(0, 1,  255, 0, 1, 32'h00C98001));
        vecs.push_back(mk(0, 1,  257, 0, 1, 32'hFF378001));
        vecs.push_back(mk(0, 1,  128, 0, 1, 32'h5A82A57E));
        vecs.push_back(mk(0, 0,  512, 0, 0, 32'h5A82A57E));
        vecs.push_back(mk(0, 0,    5, 0, 0, 32'h5A82A57E));
        vecs.push_back(mk(1, 1,  128, 0, 0, 32'h7FFF0000));
        vecs.push_back(mk(0, 1,  128, 0, 1, 32'h5A82A57E));
        vecs.push_back(mk(1, 1,  256, 0, 0, 32'h7FFF0000));
        vecs.push_back(mk(0, 0,  256, 0, 0, 32'h7FFF0000));
`ifdef FFT_TWIDDLE_INVERSE_EN
        vecs.push_back(mk(0, 1,  128, 1, 1, 32'h5A825A82));
        vecs.push_back(mk(0, 1,  256, 1, 1, 32'h00007FFF));
        vecs.push_back(mk(0, 1,  128, 0, 1, 32'h5A82A57E));
        vecs.push_back(mk(0, 1,  256, 0, 1, 32'h00008001));
        vecs.push_back(mk(0, 1,    1, 1, 1, 32'h7FFF00C9));
        vecs.push_back(mk(0, 1,  512, 1, 1, 32'h80010000));
        vecs.push_back(mk(0, 1,  640, 1, 1, 32'hA57EA57E));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].in_valid, vecs[i].n, vecs[i].inv);
            check($sformatf("vec[%0d] n=%0d", i, vecs[i].n), vecs[i].exp_valid, vecs[i].exp_tw);
        end

        // Full sweep, back-to-back, against a real-valued reference within 1 LSB.
        for (int i = 0; i < 1024; i++) begin
            real th;
            int  er, ei, gr, gi;
            drive(1'b0, 1'b1, 10'(i), 1'b0);
            th = 2.0 * 3.14159265358979323846 * real'(i) / 1024.0;
            er = round_sat(32768.0 * $cos(th));
            ei = round_sat(-32768.0 * $sin(th));
            gr = int'($signed(twiddle[31:16]));
            gi = int'($signed(twiddle[15:0]));
            n_tests++;
            if (out_valid !== 1'b1 || gr - er > 1 || er - gr > 1 || gi - ei > 1 || ei - gi > 1 ||
                gr == -32768 || gi == -32768) begin
                n_fail++;
                $display("FAIL sweep n=%0d: got valid=%0b re=%0d im=%0d, expected valid=1 re=%0d im=%0d (+-1)",
                         i, out_valid, gr, gi, er, ei);
            end
        end

        // Idle after the sweep: last value (n=1023) held, valid drops.
        drive(1'b0, 1'b0, 10'd0, 1'b0);
        check("post-sweep hold", 1'b0, 32'h7FFF00C9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
